// File: rtl/cdb_arbiter_pkg.sv
// Common data bus types and default sizing shared by the arbiter, its
// selector and anything that consumes the broadcast lanes.
package cdb_arbiter_pkg;

  localparam int CDB_NREQ   = 6;
  localparam int CDB_LANES  = 2;
  localparam int CDB_TAG_W  = 3;
  localparam int CDB_DATA_W = 32;

  typedef struct packed {
    logic                  valid;
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] data;
  } cdb_lane_t;

  typedef enum logic [2:0] {
    REQ_ALU1 = 3'd0,
    REQ_ALU2 = 3'd1,
    REQ_ALU3 = 3'd2,
    REQ_ALU4 = 3'd3,
    REQ_BR   = 3'd4,
    REQ_LD   = 3'd5
  } cdb_req_e;

endpackage

// File: rtl/cdb_arbiter_rr_select.sv
// Circular first-set-bit finder: one-hot of the first request at or after
// the start pointer, wrapping at N.
module cdb_arbiter_rr_select #(
  parameter int N     = 6,
  parameter int PTR_W = 3
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic             o_found
);

  int w_idx;

  always_comb begin
    o_grant = '0;
    o_found = 1'b0;
    w_idx   = 0;
    for (int k = 0; k < N; k++) begin
      w_idx = int'(i_ptr) + k;
      if (w_idx >= N) w_idx = w_idx - N;
      if (!o_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        o_found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin common data bus arbiter: grants up to LANES requesters per
// cycle and registers their results onto the broadcast lanes.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NREQ   = CDB_NREQ,
  parameter int LANES  = CDB_LANES,
  parameter int TAG_W  = CDB_TAG_W,
  parameter int DATA_W = CDB_DATA_W,
  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_flush,
  input  logic [NREQ-1:0]         i_req_valid,
  input  logic [NREQ*TAG_W-1:0]   i_req_tag,
  input  logic [NREQ*DATA_W-1:0]  i_req_data,
  output logic [NREQ-1:0]         o_req_grant,
  output logic [LANES-1:0]        o_cdb_valid,
  output logic [LANES*TAG_W-1:0]  o_cdb_tag,
  output logic [LANES*DATA_W-1:0] o_cdb_data,
  output logic [2**TAG_W-1:0]     o_cdb_enable,
  output logic                    o_tag_conflict,
  output logic [PTR_W-1:0]        o_rr_ptr
);

  logic [NREQ-1:0]   w_mask     [LANES];
  logic [NREQ-1:0]   w_lane_gnt [LANES];
  logic [LANES-1:0]  w_found;
  logic [TAG_W-1:0]  w_lane_tag [LANES];
  logic [DATA_W-1:0] w_lane_data[LANES];
  logic [NREQ-1:0]   w_grant;
  logic [PTR_W-1:0]  w_ptr_next;
  logic [2**TAG_W-1:0] w_en_next;
  logic              w_conflict;

  logic [LANES-1:0]        r_cdb_valid;
  logic [LANES*TAG_W-1:0]  r_cdb_tag;
  logic [LANES*DATA_W-1:0] r_cdb_data;
  logic [2**TAG_W-1:0]     r_cdb_enable;
  logic                    r_tag_conflict;
  logic [PTR_W-1:0]        r_rr_ptr;

  // Each stage sees the requests left over by the stages before it, so all
  // stages can share the same start pointer and still follow scan order.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      if (gi == 0) begin : g_first
        assign w_mask[gi] = i_req_valid & {NREQ{~i_flush & i_rst_n}};
      end else begin : g_next
        assign w_mask[gi] = w_mask[gi-1] & ~w_lane_gnt[gi-1];
      end

      cdb_arbiter_rr_select #(.N(NREQ), .PTR_W(PTR_W)) u_sel (
        .i_req   (w_mask[gi]),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_lane_gnt[gi]),
        .o_found (w_found[gi])
      );

      always_comb begin
        w_lane_tag[gi]  = '0;
        w_lane_data[gi] = '0;
        for (int r = 0; r < NREQ; r++) begin
          if (w_lane_gnt[gi][r]) begin
            w_lane_tag[gi]  = w_lane_tag[gi]  | i_req_tag[r*TAG_W +: TAG_W];
            w_lane_data[gi] = w_lane_data[gi] | i_req_data[r*DATA_W +: DATA_W];
          end
        end
      end
    end
  endgenerate

  always_comb begin
    w_grant    = '0;
    w_ptr_next = r_rr_ptr;
    w_en_next  = '0;
    for (int l = 0; l < LANES; l++) begin
      w_grant = w_grant | w_lane_gnt[l];
      if (w_found[l]) begin
        w_en_next[w_lane_tag[l]] = 1'b1;
        // Later lanes overwrite, leaving the pointer just past the last grant.
        for (int r = 0; r < NREQ; r++) begin
          if (w_lane_gnt[l][r]) w_ptr_next = (r == NREQ - 1) ? '0 : PTR_W'(r + 1);
        end
      end
    end
  end

  always_comb begin
    w_conflict = 1'b0;
    for (int a = 0; a < LANES; a++) begin
      for (int b = a + 1; b < LANES; b++) begin
        if (w_found[a] && w_found[b] && (w_lane_tag[a] == w_lane_tag[b])) w_conflict = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cdb_valid    <= '0;
      r_cdb_tag      <= '0;
      r_cdb_data     <= '0;
      r_cdb_enable   <= '0;
      r_tag_conflict <= 1'b0;
      r_rr_ptr       <= '0;
    end else begin
      r_cdb_valid    <= w_found;
      for (int l = 0; l < LANES; l++) begin
        r_cdb_tag[l*TAG_W +: TAG_W]    <= w_lane_tag[l];
        r_cdb_data[l*DATA_W +: DATA_W] <= w_lane_data[l];
      end
      r_cdb_enable   <= w_en_next;
      r_tag_conflict <= w_conflict;
      r_rr_ptr       <= w_ptr_next;
    end
  end

  assign o_req_grant    = w_grant;
  assign o_cdb_valid    = r_cdb_valid;
  assign o_cdb_tag      = r_cdb_tag;
  assign o_cdb_data     = r_cdb_data;
  assign o_cdb_enable   = r_cdb_enable;
  assign o_tag_conflict = r_tag_conflict;
  assign o_rr_ptr       = r_rr_ptr;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: hand-computed grants, lanes, enables and
// pointer values across reset, full load, wrap, flush and tag conflict.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [5:0]  req_valid;
  logic [17:0] req_tag;
  logic [191:0] req_data;
  logic [5:0]  req_grant;
  logic [1:0]  cdb_valid;
  logic [5:0]  cdb_tag;
  logic [63:0] cdb_data;
  logic [7:0]  cdb_enable;
  logic        tag_conflict;
  logic [2:0]  rr_ptr;

  logic [2:0]  tag_a  [6];
  logic [31:0] data_a [6];

  int n_vec;
  int n_err;

  cdb_arbiter dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_flush        (flush),
    .i_req_valid    (req_valid),
    .i_req_tag      (req_tag),
    .i_req_data     (req_data),
    .o_req_grant    (req_grant),
    .o_cdb_valid    (cdb_valid),
    .o_cdb_tag      (cdb_tag),
    .o_cdb_data     (cdb_data),
    .o_cdb_enable   (cdb_enable),
    .o_tag_conflict (tag_conflict),
    .o_rr_ptr       (rr_ptr)
  );

  always_comb begin
    req_tag  = '0;
    req_data = '0;
    for (int i = 0; i < 6; i++) begin
      req_tag[i*3 +: 3]   = tag_a[i];
      req_data[i*32 +: 32] = data_a[i];
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
    $display("vec %0d %s observed=%h expected=%h", n_vec, name, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic [2:0] t, input logic [31:0] d);
    tag_a[idx]  = t;
    data_a[idx] = d;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    flush = 1'b0;
    rst_n = 1'b1;
    req_valid = '0;
    for (int i = 0; i < 6; i++) set_req(i, 3'(i), 32'h100 + 32'(i));

    // Reset held with every requester valid
    #1 rst_n = 1'b0;
    req_valid = 6'b111111;
    #1;
    chk("rst_grant", 64'(req_grant), 64'h00);
    chk("rst_valid", 64'(cdb_valid), 64'h0);
    chk("rst_enable", 64'(cdb_enable), 64'h00);
    chk("rst_ptr", 64'(rr_ptr), 64'h0);
    tick();
    chk("rst_edge_grant", 64'(req_grant), 64'h00);
    chk("rst_edge_tag", 64'(cdb_tag), 64'h00);
    chk("rst_edge_data", cdb_data, 64'h0);
    chk("rst_edge_conflict", 64'(tag_conflict), 64'h0);
    chk("rst_edge_ptr", 64'(rr_ptr), 64'h0);

    // Full load: cycle 0 grants {0,1}
    rst_n = 1'b1;
    #1;
    chk("full0_grant", 64'(req_grant), 64'b000011);
    tick();
    chk("full0_valid", 64'(cdb_valid), 64'b11);
    chk("full0_tag", 64'(cdb_tag), 64'({3'd1, 3'd0}));
    chk("full0_data", cdb_data, {32'h101, 32'h100});
    chk("full0_enable", 64'(cdb_enable), 64'h03);
    chk("full0_ptr", 64'(rr_ptr), 64'd2);
    set_req(REQ_ALU1, 3'd6, 32'h200);
    set_req(REQ_ALU2, 3'd7, 32'h201);
    #1;
    chk("full1_grant", 64'(req_grant), 64'b001100);
    tick();
    chk("full1_tag", 64'(cdb_tag), 64'({3'd3, 3'd2}));
    chk("full1_data", cdb_data, {32'h103, 32'h102});
    chk("full1_enable", 64'(cdb_enable), 64'h0C);
    chk("full1_ptr", 64'(rr_ptr), 64'd4);
    #1;
    chk("full2_grant", 64'(req_grant), 64'b110000);
    tick();
    chk("full2_tag", 64'(cdb_tag), 64'({3'd5, 3'd4}));
    chk("full2_data", cdb_data, {32'h105, 32'h104});
    chk("full2_enable", 64'(cdb_enable), 64'h30);
    chk("full2_ptr_wrap", 64'(rr_ptr), 64'd0);
    #1;
    chk("full3_grant", 64'(req_grant), 64'b000011);
    tick();
    chk("full3_tag", 64'(cdb_tag), 64'({3'd7, 3'd6}));
    chk("full3_data", cdb_data, {32'h201, 32'h200});
    chk("full3_enable", 64'(cdb_enable), 64'hC0);
    chk("full3_ptr", 64'(rr_ptr), 64'd2);

    // Single requester: load unit only, pointer at 2
    req_valid = 6'b100000;
    set_req(REQ_LD, 3'd3, 32'hDEADBEEF);
    #1;
    chk("single_grant", 64'(req_grant), 64'b100000);
    tick();
    chk("single_valid", 64'(cdb_valid), 64'b01);
    chk("single_tag", 64'(cdb_tag), 64'({3'd0, 3'd3}));
    chk("single_data", cdb_data, {32'h0, 32'hDEADBEEF});
    chk("single_enable", 64'(cdb_enable), 64'h08);
    chk("single_ptr", 64'(rr_ptr), 64'd0);

    // No-request cycle
    req_valid = '0;
    #1;
    chk("idle_grant", 64'(req_grant), 64'h00);
    tick();
    chk("idle_valid", 64'(cdb_valid), 64'b00);
    chk("idle_enable", 64'(cdb_enable), 64'h00);
    chk("idle_ptr", 64'(rr_ptr), 64'd0);

    // Move pointer to 4 by granting requester 3 alone
    req_valid = 6'b001000;
    set_req(REQ_ALU4, 3'd2, 32'h33);
    #1;
    chk("p4_grant", 64'(req_grant), 64'b001000);
    tick();
    chk("p4_ptr", 64'(rr_ptr), 64'd4);

    // Wrap scan from 4: lane0 <- 4, lane1 <- 1
    req_valid = 6'b010010;
    set_req(REQ_ALU2, 3'd1, 32'h11);
    set_req(REQ_BR, 3'd4, 32'h44);
    #1;
    chk("wrap_grant", 64'(req_grant), 64'b010010);
    tick();
    chk("wrap_tag", 64'(cdb_tag), 64'({3'd1, 3'd4}));
    chk("wrap_data", cdb_data, {32'h11, 32'h44});
    chk("wrap_enable", 64'(cdb_enable), 64'h12);
    chk("wrap_ptr", 64'(rr_ptr), 64'd2);

    // Flush suppresses all grants, pointer holds
    req_valid = 6'b000101;
    flush = 1'b1;
    #1;
    chk("flush_grant", 64'(req_grant), 64'h00);
    tick();
    chk("flush_valid", 64'(cdb_valid), 64'b00);
    chk("flush_enable", 64'(cdb_enable), 64'h00);
    chk("flush_ptr", 64'(rr_ptr), 64'd2);
    flush = 1'b0;

    // Tag conflict: requesters 0 and 3 both carry tag 5, scan from 2
    req_valid = 6'b001001;
    set_req(REQ_ALU1, 3'd5, 32'hA0);
    set_req(REQ_ALU4, 3'd5, 32'hA3);
    #1;
    chk("conf_grant", 64'(req_grant), 64'b001001);
    tick();
    chk("conf_valid", 64'(cdb_valid), 64'b11);
    chk("conf_data", cdb_data, {32'hA0, 32'hA3});
    chk("conf_enable", 64'(cdb_enable), 64'h20);
    chk("conf_flag", 64'(tag_conflict), 64'h1);
    chk("conf_ptr", 64'(rr_ptr), 64'd1);
    req_valid = '0;
    tick();
    chk("conf_flag_clear", 64'(tag_conflict), 64'h0);

    // Asynchronous reset while lanes hold a broadcast
    req_valid = 6'b010100;
    tick();
    chk("mid_valid", 64'(cdb_valid), 64'b11);
    chk("mid_ptr", 64'(rr_ptr), 64'd5);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(cdb_valid), 64'b00);
    chk("mid_rst_enable", 64'(cdb_enable), 64'h00);
    chk("mid_rst_ptr", 64'(rr_ptr), 64'd0);
    chk("mid_rst_grant", 64'(req_grant), 64'h00);
    req_valid = '0;
    tick();
    rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
